// File: rtl/spi2lb.sv
`timescale 1ns/1ps
// SPI mode-0 slave bridging {addr, ctrl, data} frames to a local-bus write/read request.
// Bus request follows the last frame bit by ~4 clk; wready/rvalid stall the FSM indefinitely.
module spi2lb #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    input  logic              wready,
    output logic              ren,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid
);

    localparam int MAX_B = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_B) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CTRL,
        S_WDATA,
        S_WREQ,
        S_RREQ,
        S_RDATA,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        sck_sync, cs_sync, mosi_sync, sync_ok;
    logic              sck_d, cs_d, armed;
    logic              sck_s, cs_s, mosi_s;
    logic              sck_rise, sck_fall, cs_rise, cs_fall;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        ctrl_idx;
    logic [ADDR_W-1:0] addr_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [DATA_W-1:0] sr;
    logic              is_wr, abort_q, abort_now;

    assign sck_s    = sck_sync[1];
    assign cs_s     = cs_sync[1];
    assign mosi_s   = mosi_sync[1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;

    // A frame may only start once cs_n has been observed high through a flushed synchronizer,
    // so a reset released mid-frame does not pick up the tail of that frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sync_ok   <= 2'b00;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], spi_sck};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sync_ok   <= {sync_ok[0], 1'b1};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
            if (sync_ok[1] && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A cs_n rise during a pending bus request is remembered so the handshake ends in IDLE.
    assign abort_now = abort_q | cs_rise;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cs_fall && armed) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (cs_rise) begin
                    state_d = S_IDLE;
                end else if (sck_rise && cnt == CNT_W'(ADDR_W - 1)) begin
                    state_d = S_CTRL;
                end
            end
            S_CTRL: begin
                if (cs_rise) begin
                    state_d = S_IDLE;
                end else if (sck_rise && cnt == CNT_W'(7)) begin
                    state_d = is_wr ? S_WDATA : S_RREQ;
                end
            end
            S_WDATA: begin
                if (cs_rise) begin
                    state_d = S_IDLE;
                end else if (sck_rise && cnt == CNT_W'(DATA_W - 1)) begin
                    state_d = S_WREQ;
                end
            end
            S_WREQ: begin
                if (wready) begin
                    state_d = abort_now ? S_IDLE : S_DONE;
                end
            end
            S_RREQ: begin
                if (rvalid) begin
                    state_d = abort_now ? S_IDLE : S_RDATA;
                end
            end
            S_RDATA: begin
                if (cs_rise) begin
                    state_d = S_IDLE;
                end else if (sck_rise && cnt == CNT_W'(DATA_W - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (cs_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ctrl_idx = 3'd7 - cnt[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            addr_q  <= '0;
            wstrb_q <= '0;
            sr      <= '0;
            is_wr   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            if (state_q != state_d) begin
                cnt <= '0;
            end else if (sck_rise && (state_q == S_ADDR || state_q == S_CTRL ||
                                      state_q == S_WDATA || state_q == S_RDATA)) begin
                cnt <= cnt + 1'b1;
            end

            if (state_q != state_d) begin
                abort_q <= 1'b0;
            end else if ((state_q == S_WREQ || state_q == S_RREQ) && cs_rise) begin
                abort_q <= 1'b1;
            end

            case (state_q)
                S_ADDR: begin
                    if (sck_rise) begin
                        addr_q <= {addr_q[ADDR_W-2:0], mosi_s};
                    end
                end
                S_CTRL: begin
                    // Only ctrl[7] and the low strobe bits are kept; the bits between are don't-care.
                    if (sck_rise) begin
                        if (cnt[2:0] == 3'd0) begin
                            is_wr <= mosi_s;
                        end
                        for (int i = 0; i < STRB_W; i++) begin
                            if (ctrl_idx == 3'(i)) begin
                                wstrb_q[i] <= mosi_s;
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (sck_rise) begin
                        sr <= {sr[DATA_W-2:0], mosi_s};
                    end
                end
                S_RREQ: begin
                    if (rvalid) begin
                        sr <= rdata;
                    end
                end
                S_RDATA: begin
                    // The fall closing the last ctrl bit arrives here before any data rise;
                    // skipping it keeps the MSB on miso for the first data-phase rise.
                    if (sck_fall && cnt != '0) begin
                        sr <= {sr[DATA_W-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign wen      = (state_q == S_WREQ);
    assign ren      = (state_q == S_RREQ);
    assign waddr    = addr_q;
    assign raddr    = addr_q;
    assign wdata    = sr;
    assign wstrb    = wstrb_q;
    assign spi_miso = (state_q == S_RDATA) & sr[DATA_W-1];

endmodule

// File: doc/spi2lb.md
SPI2LB -- requirements
Module: spi2lb

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning address bits per transaction and local-bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data bits per transaction; it SHALL be a multiple of 8, with 8 <= DATA_W <= 32.
REQ-003 SHALL derive STRB_W = DATA_W/8.
REQ-004 SHALL have port clk, input, 1 bit, system clock; SPI inputs are oversampled and clk SHALL be >= 8x sck.
REQ-005 SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-006 SHALL have port spi_sck, input, 1 bit, SPI clock, mode 0.
REQ-007 SHALL have port spi_cs_n, input, 1 bit, chip select, active low.
REQ-008 SHALL have port spi_mosi, input, 1 bit, master-out data.
REQ-009 SHALL have port spi_miso, output, 1 bit, slave-out data.
REQ-010 SHALL have port wen, output, 1 bit, write request.
REQ-011 SHALL have port waddr, output, ADDR_W bits, write address.
REQ-012 SHALL have port wdata, output, DATA_W bits, write data.
REQ-013 SHALL have port wstrb, output, STRB_W bits, byte strobes.
REQ-014 SHALL have port wready, input, 1 bit, write accepted.
REQ-015 SHALL have port ren, output, 1 bit, read request.
REQ-016 SHALL have port raddr, output, ADDR_W bits, read address.
REQ-017 SHALL have port rdata, input, DATA_W bits, read data.
REQ-018 SHALL have port rvalid, input, 1 bit, rdata valid.

Function
REQ-019 SHALL pass spi_sck, spi_cs_n and spi_mosi through 2-FF synchronizers, reset to 0, 1 and 0, and SHALL detect sck rise/fall edges from the synchronized values.
REQ-020 SHALL run the FSM states IDLE, ADDR, CTRL, WDATA, WREQ, RREQ, RDATA and DONE.
- IDLE -> ADDR on synchronized cs_n falling.
REQ-021 SHALL sample mosi MSB-first on each sck rise; a bit counter SHALL move ADDR -> CTRL after ADDR_W bits, and CTRL after 8 bits -> WDATA if ctrl[7]=1, else -> RREQ.
REQ-022 SHALL take wstrb = ctrl[STRB_W-1:0] and ignore ctrl[6:STRB_W].
REQ-023 SHALL move WDATA -> WREQ on the clk after the DATA_W-th rise.
- In WREQ: wen=1 with waddr/wdata/wstrb stable until the cycle wready=1.
- Then -> DONE; wen drops the next cycle.
REQ-024 SHALL, in RREQ, assert ren=1 with raddr stable until rvalid=1, capturing rdata into the shift register on that cycle; then -> RDATA.
REQ-025 SHALL drive spi_miso from shift-register MSB in RDATA, shifting left on each sck fall; the first bit SHALL be valid before the first data-phase sck rise; after DATA_W bits -> DONE.
REQ-026 SHALL specify that rvalid must arrive within 3 clk of ren for correct miso timing; late rvalid SHALL still complete the handshake, shifted data then undefined.
REQ-027 SHALL drive spi_miso = 0 outside RDATA.
REQ-028 SHALL go DONE -> IDLE on synchronized cs_n high.
REQ-029 SHALL, on cs_n rising in ADDR/CTRL/WDATA/RDATA, abort to IDLE, discard partial data and issue no bus request.
REQ-030 SHALL, on cs_n rising in WREQ/RREQ, finish the handshake and then go to IDLE.
REQ-031 SHALL ignore extra sck edges in DONE.
REQ-032 SHALL never assert wen and ren simultaneously.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously force state=IDLE, counters=0, wen=0, ren=0, spi_miso=0, and waddr/raddr/wdata/wstrb/shift register=0.
REQ-034 SHALL, on reset assertion mid-transaction, drop any pending wen/ren immediately.
REQ-035 SHALL, after reset release with cs_n low, stay IDLE until cs_n is seen high then low.

Verification (ADDR_W=8, DATA_W=32, clk=100 MHz, sck=4 MHz)
REQ-036 SHALL verify: write addr 0x24, data 0xDEADBEEF, strb 0xF, wready tied 1 -> one wen pulse, waddr=0x24, wdata=0xDEADBEEF, wstrb=0xF.
REQ-037 SHALL verify: write strb 0x5, wready delayed 5 clk -> wen held 6 cycles, outputs stable, wstrb=0x5.
REQ-038 SHALL verify: read addr 0x10, rdata=0xCAFE0123 with rvalid 1 clk after ren -> master receives 0xCAFE0123, a single ren handshake.
REQ-039 SHALL verify: cs_n raised after 12 bits of a write -> no wen; the next full write completes normally.
REQ-040 SHALL verify: rst_n pulsed low during the WREQ wait -> wen=0 the same cycle, FSM IDLE, a following read returns correct data.
REQ-041 SHALL verify: back-to-back write then read with 2 clk cs_n-high gap -> both correct, miso=0 throughout the write.
